// File: rtl/display_pkg.sv
// Shared definitions for the display path: converter state encoding,
// digit count and the largest value the four-digit display can show.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int BCD_DIGITS       = 4;
   localparam int MAX_DISPLAY      = 9999;
   localparam int IN_WIDTH_DEFAULT = 14;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit corrector: a nibble of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] corrected
);

   assign corrected = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3). A value is accepted
// over Valid/Ready, converted over IN_WIDTH cycles in a scratch register, and
// the four digits plus the overflow flag are published together in one edge.
module bcd_converter
   import display_pkg::*;
#(
   parameter int IN_WIDTH  = IN_WIDTH_DEFAULT,
   parameter int MAX_VALUE = MAX_DISPLAY
) (
   input  logic                Clk,
   input  logic                nReset,
   input  logic [IN_WIDTH-1:0] Value,
   input  logic                Valid,
   output logic                Ready,
   output logic [3:0]          BCD3,
   output logic [3:0]          BCD2,
   output logic [3:0]          BCD1,
   output logic [3:0]          BCD0,
   output logic                Overflow,
   output logic                Done
);

   localparam int BCD_W  = 4 * BCD_DIGITS;
   localparam int ITER_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam logic [IN_WIDTH-1:0] MAX_IN    = IN_WIDTH'(MAX_VALUE);
   localparam logic [ITER_W-1:0]   LAST_ITER = ITER_W'(IN_WIDTH - 1);

   conv_state_t               state;
   conv_state_t               state_next;
   logic [ITER_W-1:0]         iter;
   logic [BCD_W+IN_WIDTH-1:0] scratch;
   logic [BCD_W-1:0]          corrected;
   logic                      ovf;
   logic                      accept;
   logic                      too_big;

   assign Ready   = (state == IDLE);
   assign accept  = Valid && Ready;
   assign too_big = (Value > MAX_IN);

   genvar g;
   generate
      for (g = 0; g < BCD_DIGITS; g++) begin : g_digit
         bcd_add3 u_add3 (
            .digit     (scratch[IN_WIDTH + 4*g +: 4]),
            .corrected (corrected[4*g +: 4])
         );
      end
   endgenerate

   // State register for the accept / shift / publish sequence
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: leave IDLE on accept, shift IN_WIDTH times, publish once
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (iter == LAST_ITER) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Scratch datapath: load the saturated value, then correct-and-shift each cycle
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         scratch <= '0;
         iter    <= '0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  scratch <= {{BCD_W{1'b0}}, (too_big ? MAX_IN : Value)};
                  ovf     <= too_big;
                  iter    <= '0;
               end
            end
            SHIFT: begin
               scratch <= {corrected, scratch[IN_WIDTH-1:0]} << 1;
               iter    <= iter + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Output registers change only in DONE so the display never sees partial digits
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         BCD3     <= 4'd0;
         BCD2     <= 4'd0;
         BCD1     <= 4'd0;
         BCD0     <= 4'd0;
         Overflow <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (state == DONE) begin
            BCD3     <= scratch[IN_WIDTH + 12 +: 4];
            BCD2     <= scratch[IN_WIDTH + 8  +: 4];
            BCD1     <= scratch[IN_WIDTH + 4  +: 4];
            BCD0     <= scratch[IN_WIDTH      +: 4];
            Overflow <= ovf;
            Done     <= 1'b1;
         end
      end
   end

endmodule
